// File: rtl/wb_trace_fifo_if.sv
// Bundles the writeback-capture inputs and the trace drain port of wb_trace_fifo.
// slave = the FIFO itself; master = the core tap plus trace consumer.
interface wb_trace_fifo_if #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 8
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic              wb_we;
    logic [4:0]        wb_reg;
    logic [31:0]       wb_data;
    logic              trace_valid;
    logic              trace_ready;
    logic [4:0]        trace_reg;
    logic [31:0]       trace_data;
    logic [15:0]       trace_time;
    logic [LW-1:0]     level;
    logic              overflow;
    logic [DROP_W-1:0] drop_count;

    modport slave (
        input  wb_we, wb_reg, wb_data, trace_ready,
        output trace_valid, trace_reg, trace_data, trace_time,
               level, overflow, drop_count
    );

    modport master (
        output wb_we, wb_reg, wb_data, trace_ready,
        input  trace_valid, trace_reg, trace_data, trace_time,
               level, overflow, drop_count
    );
endinterface

// File: rtl/wb_trace_fifo.sv
// Writeback trace FIFO: captures non-$zero register writebacks, drains via valid/ready,
// drops and counts events on overflow. Define WB_TRACE_TIMESTAMP_EN to store cycle timestamps.
module wb_trace_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 8
) (
    input logic            clk,
    input logic            reset,
    wb_trace_fifo_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [AW-1:0]     wp_q, wp_d;
    logic [AW-1:0]     rp_q, rp_d;
    logic [LW-1:0]     level_q, level_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic capture, pop, full, push, drop;

    logic [4:0]  reg_mem  [DEPTH];
    logic [31:0] data_mem [DEPTH];

`ifdef WB_TRACE_TIMESTAMP_EN
    logic [15:0] ts_q, ts_d;
    logic [15:0] ts_mem [DEPTH];
`endif

    always_comb begin
        capture = bus.wb_we && (bus.wb_reg != 5'd0);
        pop     = (level_q != '0) && bus.trace_ready;
        full    = (level_q == LW'(DEPTH));
        // A pop in the same edge frees a slot, so a full FIFO still accepts.
        push    = capture && (!full || pop);
        drop    = capture && full && !pop;

        wp_d = push ? wp_q + AW'(1) : wp_q;
        rp_d = pop  ? rp_q + AW'(1) : rp_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        overflow_d = overflow_q | drop;
        drop_d     = (drop && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
`ifdef WB_TRACE_TIMESTAMP_EN
        ts_d = ts_q + 16'd1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q       <= '0;
            rp_q       <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
`ifdef WB_TRACE_TIMESTAMP_EN
            ts_q       <= '0;
`endif
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
`ifdef WB_TRACE_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    // Storage is not reset; the level counter alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wp_q]  <= bus.wb_reg;
            data_mem[wp_q] <= bus.wb_data;
`ifdef WB_TRACE_TIMESTAMP_EN
            ts_mem[wp_q]   <= ts_q;
`endif
        end
    end

    assign bus.trace_valid = (level_q != '0);
    assign bus.trace_reg   = reg_mem[rp_q];
    assign bus.trace_data  = data_mem[rp_q];
`ifdef WB_TRACE_TIMESTAMP_EN
    assign bus.trace_time  = ts_mem[rp_q];
`else
    assign bus.trace_time  = 16'h0000;
`endif
    assign bus.level       = level_q;
    assign bus.overflow    = overflow_q;
    assign bus.drop_count  = drop_q;
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Randomized + directed bench for wb_trace_fifo with a queue-based reference model
// and a scoreboard monitor that checks every drained entry.
module tb_wb_trace_fifo;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned DROP_W = 8;
    localparam int          MAXD   = (1 << DROP_W) - 1;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic [15:0] t;
    } ev_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    wb_trace_fifo_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    wb_trace_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    endfunction

    // Reference model: occupancy count, sticky overflow, saturating drops, cycle counter.
    ev_t  exp_q[$];
    int   m_level;
    int   m_ts;
    bit   m_ovf;
    int   m_drop;
    logic m_pop, m_cap, m_acc;

    assign m_pop = (m_level != 0) && bus.trace_ready;
    assign m_cap = bus.wb_we && (bus.wb_reg != 5'd0);
    assign m_acc = m_cap && ((m_level < DEPTH) || m_pop);

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_level <= 0;
            m_ts    <= 0;
            m_ovf   <= 1'b0;
            m_drop  <= 0;
            exp_q.delete();
        end else begin
            if (m_acc) begin
`ifdef WB_TRACE_TIMESTAMP_EN
                exp_q.push_back('{bus.wb_reg, bus.wb_data, 16'(m_ts)});
`else
                exp_q.push_back('{bus.wb_reg, bus.wb_data, 16'h0000});
`endif
            end
            if (m_cap && !m_acc) begin
                m_ovf <= 1'b1;
                if (m_drop < MAXD) m_drop <= m_drop + 1;
            end
            m_level <= m_level + int'(m_acc) - int'(m_pop);
            m_ts    <= (m_ts + 1) % 65536;
        end
    end

    // Monitor: status every cycle, head entry on every handshake.
    always @(negedge clk) begin
        if (reset) begin
            chk("level", 64'(bus.level), 64'(m_level));
            chk("valid", 64'(bus.trace_valid), 64'(m_level != 0));
            chk("overflow", 64'(bus.overflow), 64'(m_ovf));
            chk("drop_count", 64'(bus.drop_count), 64'(m_drop));
            if (bus.trace_valid && bus.trace_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_pop", 64'(1), 64'(0));
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("head_reg", 64'(bus.trace_reg), 64'(e.r));
                    chk("head_data", 64'(bus.trace_data), 64'(e.d));
                    chk("head_time", 64'(bus.trace_time), 64'(e.t));
                end
            end
        end
    end

    task automatic step(input bit we, input logic [4:0] r, input logic [31:0] d, input bit rdy);
        bus.wb_we       = we;
        bus.wb_reg      = r;
        bus.wb_data     = d;
        bus.trace_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && bus.trace_valid; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1);
        chk("drain_done", 64'(bus.trace_valid), 64'(0));
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        bus.wb_we = 1'b0; bus.wb_reg = '0; bus.wb_data = '0; bus.trace_ready = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 64'(bus.trace_valid), 64'(0));
        chk("rst_level", 64'(bus.level), 64'(0));
        chk("rst_overflow", 64'(bus.overflow), 64'(0));
        chk("rst_drop", 64'(bus.drop_count), 64'(0));
        reset = 1'b1;

        // Single capture at edge 3 (edge 0 is the first after release).
        repeat (3) step(1'b0, 5'd0, 32'd0, 1'b0);
        step(1'b1, 5'd16, 32'h0000_0005, 1'b0);
        chk("single_valid", 64'(bus.trace_valid), 64'(1));
        chk("single_reg", 64'(bus.trace_reg), 64'(16));
        chk("single_data", 64'(bus.trace_data), 64'(5));
`ifdef WB_TRACE_TIMESTAMP_EN
        chk("single_time", 64'(bus.trace_time), 64'(3));
`else
        chk("single_time", 64'(bus.trace_time), 64'(0));
`endif
        chk("single_level", 64'(bus.level), 64'(1));
        drain();

        // Writes to $zero are ignored entirely.
        repeat (5) step(1'b1, 5'd0, $urandom, 1'b0);
        chk("zero_level", 64'(bus.level), 64'(0));
        chk("zero_overflow", 64'(bus.overflow), 64'(0));
        chk("zero_drop", 64'(bus.drop_count), 64'(0));

        // Fill past capacity, then push+pop while full.
        for (int i = 1; i <= 20; i++)
            step(1'b1, 5'($urandom_range(1, 31)), 32'(i), 1'b0);
        chk("fill_level", 64'(bus.level), 64'(16));
        chk("fill_overflow", 64'(bus.overflow), 64'(1));
        chk("fill_drop", 64'(bus.drop_count), 64'(4));
        chk("fill_head", 64'(bus.trace_data), 64'(1));
        step(1'b1, 5'd7, 32'h0000_00AB, 1'b1);
        chk("full_pp_level", 64'(bus.level), 64'(16));
        chk("full_pp_drop", 64'(bus.drop_count), 64'(4));
        drain();

        // Back-to-back streaming through pointer wrap.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1);
            chk("stream_level_le1", 64'(bus.level <= 1), 64'(1));
        end
        drain();

        // Asynchronous reset mid-operation.
        for (int i = 0; i < 7; i++)
            step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0);
        chk("pre_rst_level", 64'(bus.level), 64'(7));
        #1 reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(bus.trace_valid), 64'(0));
        chk("mid_rst_level", 64'(bus.level), 64'(0));
        chk("mid_rst_overflow", 64'(bus.overflow), 64'(0));
        chk("mid_rst_drop", 64'(bus.drop_count), 64'(0));
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b1, 5'd9, 32'h0000_0077, 1'b0);
        chk("post_rst_reg", 64'(bus.trace_reg), 64'(9));
        chk("post_rst_data", 64'(bus.trace_data), 64'(32'h77));
        chk("post_rst_time", 64'(bus.trace_time), 64'(0));
        drain();

        // Random traffic: bursty writebacks, some to $zero, random consumer stalls.
        for (int i = 0; i < 400; i++) begin
            bit burst;
            burst = (i / 50) % 2 == 1;
            step(($urandom_range(0, 99) < (burst ? 90 : 50)),
                 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 99) < (burst ? 30 : 70)));
        end
        drain();
        chk("sb_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
